// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One-entry holding register lets the next byte queue mid-frame for gapless chaining.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       hold;
  logic [7:0]       shift;
  logic             par_q;
  logic             tick;

  assign tick = (cnt == '0);

  // Parity bit makes the ones count even (PARITY=2) or odd (PARITY=1).
  function automatic logic par_of(input logic [7:0] b);
    return (PARITY == 2) ? ^b : ~^b;
  endfunction

  // ready_o is the registered complement of the holding-register full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      hold    <= '0;
      shift   <= '0;
      par_q   <= 1'b0;
      ready_o <= 1'b1;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;

      if (valid_i && ready_o) begin
        hold    <= d_i;
        ready_o <= 1'b0;
      end

      if (state != S_IDLE) begin
        cnt <= tick ? CNT_LOAD : cnt - CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          if (!ready_o) begin
            shift   <= hold;
            par_q   <= par_of(hold);
            ready_o <= 1'b1;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
            cnt     <= CNT_LOAD;
            state   <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            tx_o    <= shift[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                tx_o  <= par_q;
                state <= S_PARITY;
              end else begin
                tx_o  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              shift   <= shift >> 1;
              tx_o    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        S_PARITY: begin
          if (tick) begin
            tx_o    <= 1'b1;
            bit_idx <= '0;
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              done_o  <= 1'b1;
              bit_idx <= '0;
              if (!ready_o) begin
                // Chain straight into the next start bit with no idle cycle.
                shift   <= hold;
                par_q   <= par_of(hold);
                ready_o <= 1'b1;
                tx_o    <= 1'b0;
                state   <= S_START;
              end else begin
                busy_o <= 1'b0;
                state  <= S_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        default: begin
          tx_o    <= 1'b1;
          busy_o  <= 1'b0;
          bit_idx <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no/odd/even parity and two stop bits.
module tb_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d [4];
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] mem [4][16];
  int         wr_ptr [4];
  int         rd_ptr [4];
  logic [3:0] rdy_prev;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .d_i(d[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .d_i(d[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .d_i(d[2]), .valid_i(valid[2]),
    .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY(0)) u3 (
    .clk(clk), .reset(reset), .d_i(d[3]), .valid_i(valid[3]),
    .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));

  // Per-channel byte queue driver; d_i is scrambled whenever ready_o is low.
  initial begin
    valid    = '0;
    rdy_prev = '0;
    for (int i = 0; i < 4; i++) begin
      d[i]      = 8'h00;
      rd_ptr[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (valid[i] && rdy_prev[i]) rd_ptr[i]++;
        if (rd_ptr[i] != wr_ptr[i]) begin
          valid[i] = 1'b1;
          d[i]     = ready[i] ? mem[i][rd_ptr[i] % 16] : 8'($urandom);
        end else begin
          valid[i] = 1'b0;
          d[i]     = 8'($urandom);
        end
        rdy_prev[i] = ready[i];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wr_ptr[i] % 16] = b;
    wr_ptr[i]++;
  endtask

  task automatic wait_start(input int i);
    int n = 0;
    while (tx[i] !== 1'b0 && n < 400) begin
      step();
      n++;
    end
    chk($sformatf("ch%0d_start_seen", i), 32'(n < 400), 32'd1);
  endtask

  // Called on the first cycle of the start bit; returns on the cycle after the last stop bit.
  task automatic check_frame(input int i, input logic [7:0] b, input int pen,
                             input logic pbit, input int stops,
                             input bit chained_in, input bit chained_out);
    int          nb;
    int          good;
    int          bad_busy = 0;
    int          bad_done = 0;
    logic [11:0] expb;
    nb   = 10 + pen + stops - 1;
    expb = '1;
    expb[0] = 1'b0;
    for (int j = 0; j < 8; j++) expb[1+j] = b[j];
    if (pen != 0) expb[9] = pbit;
    for (int bt = 0; bt < nb; bt++) begin
      good = 0;
      for (int c = 0; c < int'(CPB); c++) begin
        if (tx[i] === expb[bt]) good++;
        if (busy[i] !== 1'b1) bad_busy++;
        if (done[i] !== 1'b0 && !(chained_in && bt == 0 && c == 0)) bad_done++;
        if (chained_out && bt == nb - 1 && c == int'(CPB) - 1)
          chk($sformatf("ch%0d_%h_ready_low_before_chain", i, b), 32'(ready[i]), 32'd0);
        step();
      end
      chk($sformatf("ch%0d_%h_bit%0d", i, b, bt), 32'(good), CPB);
    end
    chk($sformatf("ch%0d_%h_busy_in_frame", i, b), 32'(bad_busy), 32'd0);
    chk($sformatf("ch%0d_%h_no_early_done", i, b), 32'(bad_done), 32'd0);
    chk($sformatf("ch%0d_%h_done_pulse", i, b), 32'(done[i]), 32'd1);
    chk($sformatf("ch%0d_%h_tx_after", i, b), 32'(tx[i]), chained_out ? 32'd0 : 32'd1);
    chk($sformatf("ch%0d_%h_busy_after", i, b), 32'(busy[i]), chained_out ? 32'd1 : 32'd0);
    if (chained_out)
      chk($sformatf("ch%0d_%h_ready_after_chain", i, b), 32'(ready[i]), 32'd1);
  endtask

  initial begin
    int n;
    int cnt_done;
    int cnt_low;
    logic [7:0] seq [5];
    seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h78; seq[4] = 8'h9A;
    for (int i = 0; i < 4; i++) wr_ptr[i] = 0;

    // Reset state on all four instances
    reset = 1'b1;
    repeat (3) step();
    chk("rst_tx",    32'(tx),    32'hF);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_ready", 32'(ready), 32'hF);
    chk("rst_done",  32'(done),  32'h0);
    reset = 1'b0;
    step();

    // Reset asserted during the data bits aborts the frame
    push(0, 8'h3C);
    wait_start(0);
    repeat (8) step();
    chk("t1_busy_mid", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    step();
    chk("t1_rst_tx",    32'(tx[0]),    32'd1);
    chk("t1_rst_busy",  32'(busy[0]),  32'd0);
    chk("t1_rst_ready", 32'(ready[0]), 32'd1);
    reset = 1'b0;
    cnt_done = 0;
    cnt_low  = 0;
    for (int k = 0; k < 50; k++) begin
      if (done[0] !== 1'b0) cnt_done++;
      if (tx[0] !== 1'b1) cnt_low++;
      step();
    end
    chk("t1_no_done", 32'(cnt_done), 32'd0);
    chk("t1_idle_tx", 32'(cnt_low), 32'd0);

    // Single 0xA5 frame with one-cycle accept-to-start latency
    push(0, 8'hA5);
    n = 0;
    while (rd_ptr[0] != wr_ptr[0] && n < 50) begin
      step();
      n++;
    end
    chk("t2_accepted", 32'(n < 50), 32'd1);
    chk("t2_tx_at_accept", 32'(tx[0]), 32'd1);
    chk("t2_ready_at_accept", 32'(ready[0]), 32'd0);
    step();
    chk("t2_start_latency", 32'(tx[0]), 32'd0);
    check_frame(0, 8'hA5, 0, 1'b0, 1, 1'b0, 1'b0);

    // Back-to-back 0x00 then 0xFF with no gap
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_start(0);
    check_frame(0, 8'h00, 0, 1'b0, 1, 1'b0, 1'b1);
    check_frame(0, 8'hFF, 0, 1'b0, 1, 1'b1, 1'b0);

    // Odd parity (instance 1) and even parity (instance 2)
    push(1, 8'h01); wait_start(1); check_frame(1, 8'h01, 1, 1'b0, 1, 1'b0, 1'b0);
    push(1, 8'h03); wait_start(1); check_frame(1, 8'h03, 1, 1'b1, 1, 1'b0, 1'b0);
    push(2, 8'h01); wait_start(2); check_frame(2, 8'h01, 1, 1'b1, 1, 1'b0, 1'b0);
    push(2, 8'h03); wait_start(2); check_frame(2, 8'h03, 1, 1'b0, 1, 1'b0, 1'b0);

    // Two stop bits
    push(3, 8'h5A); wait_start(3); check_frame(3, 8'h5A, 0, 1'b0, 2, 1'b0, 1'b0);

    // Five bytes with valid_i held and d_i scrambled while not ready
    for (int k = 0; k < 5; k++) push(0, seq[k]);
    wait_start(0);
    for (int k = 0; k < 5; k++)
      check_frame(0, seq[k], 0, 1'b0, 1, k > 0, k < 4);
    cnt_low = 0;
    for (int k = 0; k < 30; k++) begin
      if (tx[0] !== 1'b1) cnt_low++;
      step();
    end
    chk("t6_no_extra_frames", 32'(cnt_low), 32'd0);
    chk("t6_all_accepted", 32'(rd_ptr[0]), 32'(wr_ptr[0]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
